// File: rtl/reg_file_if.sv
// Register-file bus: read ports A/B, write port and flag capture port.
// Signal names match the register-file datasheet. The master (datapath or
// bench) drives addresses and writes. The slave (reg_file) returns read data
// and flags. There is no handshake: every request is accepted on the rising
// clock edge when its enable is high.
interface reg_file_if #(
    parameter int W  = 8,
    parameter int AW = 3
);
    logic [AW-1:0] ra_addr;
    logic [AW-1:0] rb_addr;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic          flag_we;
    logic          zero_in;
    logic          cout_in;
    logic          zero_f;
    logic          carry_f;

    modport master (
        output ra_addr, rb_addr, wr_en, wr_addr, wr_data, flag_we, zero_in, cout_in,
        input  A, B, zero_f, carry_f
    );

    modport slave (
        input  ra_addr, rb_addr, wr_en, wr_addr, wr_data, flag_we, zero_in, cout_in,
        output A, B, zero_f, carry_f
    );
endinterface

// File: rtl/reg_file.sv
// reg_file: NREG x W register file with two combinational read ports,
// one write port, and a zero/carry flag register.
// R0 is hard-wired to zero and is never written or forwarded.
// Optional macro RF_BYPASS_EN forwards write data to a read port that
// addresses the register being written in the same cycle.
// Without the macro, a read port shows the pre-edge stored value.
// Reset is asynchronous and active-low. While reset is asserted, writes
// and flag captures are ignored.
module reg_file #(
    parameter int W    = 8,
    parameter int NREG = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    reg_file_if.slave   rf
);
    localparam int AW = $clog2(NREG);

    logic [W-1:0] regs_q [NREG];
    logic [W-1:0] regs_d [NREG];
    logic         zero_f_q, zero_f_d;
    logic         carry_f_q, carry_f_d;
    logic         wr_fire;
    logic [W-1:0] rd_a;
    logic [W-1:0] rd_b;

    // A write is live only outside reset and only to a nonzero register
    assign wr_fire = rst_n && rf.wr_en && (rf.wr_addr != '0);

    // Next-state for storage and flags; the two enables are independent
    always_comb begin
        regs_d    = regs_q;
        zero_f_d  = zero_f_q;
        carry_f_d = carry_f_q;
        if (wr_fire) begin
            regs_d[rf.wr_addr] = rf.wr_data;
        end
        if (rf.flag_we) begin
            zero_f_d  = rf.zero_in;
            carry_f_d = rf.cout_in;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            zero_f_q  <= 1'b0;
            carry_f_q <= 1'b0;
        end else begin
            regs_q    <= regs_d;
            zero_f_q  <= zero_f_d;
            carry_f_q <= carry_f_d;
        end
    end

    // Combinational read ports, optionally forwarding same-cycle write data
    always_comb begin
        rd_a = regs_q[rf.ra_addr];
        rd_b = regs_q[rf.rb_addr];
`ifdef RF_BYPASS_EN
        if (wr_fire && (rf.wr_addr == rf.ra_addr)) begin
            rd_a = rf.wr_data;
        end
        if (wr_fire && (rf.wr_addr == rf.rb_addr)) begin
            rd_b = rf.wr_data;
        end
`else
        // Forwarding is disabled, so a read port shows the stored value
`endif
    end

    assign rf.A       = rd_a;
    assign rf.B       = rd_b;
    assign rf.zero_f  = zero_f_q;
    assign rf.carry_f = carry_f_q;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file. A behavioural array model holds the
// register contents and the flag values. Directed scenarios run first,
// then randomized traffic.
module tb_reg_file;
  localparam int W    = 8;
  localparam int NREG = 8;
  localparam int AW   = 3;

  logic clk;
  logic rst_n;

  reg_file_if #(.W(W), .AW(AW)) rf ();

  reg_file #(.W(W), .NREG(NREG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rf    (rf.slave)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  int m_regs [NREG];
  int m_zf;
  int m_cf;
  int n_checks;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_regs[i] = 0;
    m_zf = 0;
    m_cf = 0;
  endtask

  // Value a read port must show before the edge of a cycle
  function automatic int exp_read(input int ra, input logic we, input int wa, input int wd);
    if (ra == 0) return 0;
`ifdef RF_BYPASS_EN
    if (we && wa == ra) return wd;
`endif
    return m_regs[ra];
  endfunction

  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                       input logic fwe, input logic z, input logic c,
                       input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    rf.wr_en   = we;
    rf.wr_addr = wa;
    rf.wr_data = wd;
    rf.flag_we = fwe;
    rf.zero_in = z;
    rf.cout_in = c;
    rf.ra_addr = ra;
    rf.rb_addr = rb;
  endtask

  // One bus cycle. Drive at the falling edge, check the reads before the
  // rising edge, then update the model and check the flags after the edge.
  task automatic cycle(input logic we, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                       input logic fwe, input logic z, input logic c,
                       input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    @(negedge clk);
    drive(we, wa, wd, fwe, z, c, ra, rb);
    #2;
    check("rd_a", 32'(rf.A), 32'(exp_read(int'(ra), we, int'(wa), int'(wd))));
    check("rd_b", 32'(rf.B), 32'(exp_read(int'(rb), we, int'(wa), int'(wd))));
    @(posedge clk);
    if (we && wa != 0) m_regs[wa] = int'(wd);
    if (fwe) begin
      m_zf = int'(z);
      m_cf = int'(c);
    end
    #1;
    check("zero_f", 32'(rf.zero_f), 32'(m_zf));
    check("carry_f", 32'(rf.carry_f), 32'(m_cf));
  endtask

  task automatic idle_read(input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, ra, rb);
  endtask

  logic [W-1:0] alu_o;
  logic [AW-1:0] r_ra, r_rb, r_wa;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_reset();
    drive(1'b1, 3'd4, 8'h99, 1'b1, 1'b1, 1'b1, 3'd4, 3'd4);
    rst_n = 1'b0;

    // Reset state: random addresses read zero and the flags are clear
    repeat (3) begin
      @(negedge clk);
      rf.ra_addr = AW'($urandom_range(0, NREG - 1));
      rf.rb_addr = AW'($urandom_range(0, NREG - 1));
      rf.wr_addr = rf.ra_addr;
      #2;
      check("rst_a", 32'(rf.A), 32'h0);
      check("rst_b", 32'(rf.B), 32'h0);
      check("rst_zf", 32'(rf.zero_f), 32'h0);
      check("rst_cf", 32'(rf.carry_f), 32'h0);
    end
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b1;
    for (int r = 1; r < NREG; r++) idle_read(AW'(r), AW'(r));

    // Write and read back, then write the adder result of the two reads
    cycle(1'b1, 3'd3, 8'hA5, 1'b0, 1'b0, 1'b0, 3'd3, 3'd0);
    cycle(1'b1, 3'd5, 8'h3C, 1'b0, 1'b0, 1'b0, 3'd5, 3'd3);
    idle_read(3'd3, 3'd5);
    check("a_r3", 32'(rf.A), 32'hA5);
    check("b_r5", 32'(rf.B), 32'h3C);
    alu_o = W'(m_regs[3] + m_regs[5]);
    cycle(1'b1, 3'd6, alu_o, 1'b0, 1'b0, 1'b0, 3'd3, 3'd5);
    idle_read(3'd6, 3'd6);
    check("r6_alu", 32'(rf.A), 32'hE1);

    // A write to R0 is dropped and must not disturb other registers
    cycle(1'b1, 3'd0, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
    idle_read(3'd0, 3'd0);
    check("r0_zero", 32'(rf.A), 32'h0);
    for (int r = 1; r < NREG; r++) idle_read(AW'(r), 3'd0);

    // The flags capture together and hold while flag_we is low
    cycle(1'b0, '0, '0, 1'b1, 1'b1, 1'b1, 3'd1, 3'd2);
    check("zf_set", 32'(rf.zero_f), 32'h1);
    check("cf_set", 32'(rf.carry_f), 32'h1);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 3'd1, 3'd2);
    check("zf_hold", 32'(rf.zero_f), 32'h1);
    check("cf_hold", 32'(rf.carry_f), 32'h1);

    // Read during write on the same register, on both ports
    cycle(1'b1, 3'd2, 8'h10, 1'b0, 1'b0, 1'b0, 3'd1, 3'd1);
    cycle(1'b1, 3'd2, 8'h77, 1'b0, 1'b0, 1'b0, 3'd2, 3'd2);
    idle_read(3'd2, 3'd2);
    check("byp_after", 32'(rf.A), 32'h77);

    // A write and a flag capture in the same cycle
    cycle(1'b1, 3'd7, 8'h5A, 1'b1, 1'b0, 1'b1, 3'd7, 3'd0);
    idle_read(3'd7, 3'd0);

    // Async reset between edges with a write to R4 pending
    cycle(1'b1, 3'd4, 8'h33, 1'b0, 1'b0, 1'b0, 3'd4, 3'd3);
    @(negedge clk);
    drive(1'b1, 3'd4, 8'h55, 1'b1, 1'b1, 1'b1, 3'd4, 3'd3);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_a", 32'(rf.A), 32'h0);
    check("arst_b", 32'(rf.B), 32'h0);
    check("arst_zf", 32'(rf.zero_f), 32'h0);
    check("arst_cf", 32'(rf.carry_f), 32'h0);
    @(posedge clk);
    #1;
    check("arst_edge_a", 32'(rf.A), 32'h0);
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 3'd4, 3'd3);
    rst_n = 1'b1;
    idle_read(3'd4, 3'd3);
    check("r4_cleared", 32'(rf.A), 32'h0);
    cycle(1'b1, 3'd4, 8'h55, 1'b0, 1'b0, 1'b0, 3'd1, 3'd4);
    idle_read(3'd4, 3'd4);
    check("r4_first_wr", 32'(rf.A), 32'h55);

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      r_ra = AW'($urandom_range(0, NREG - 1));
      r_rb = ($urandom_range(0, 3) == 0) ? r_ra : AW'($urandom_range(0, NREG - 1));
      r_wa = ($urandom_range(0, 2) == 0) ? r_ra : AW'($urandom_range(0, NREG - 1));
      cycle(1'($urandom_range(0, 1)), r_wa, W'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            r_ra, r_rb);
      if (r_ra == r_rb) check("same_addr", 32'(rf.A), 32'(rf.B));
    end
    for (int r = 0; r < NREG; r++) idle_read(AW'(r), AW'(NREG - 1 - r));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter W, default 8, data width of every register and data port; matches the ALU operand width.
REQ-002 Parameter NREG, default 8, number of architectural registers; address width AW = log2(NREG), 3 at default.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 ra_addr  input  AW  read port A register select.
REQ-007 rb_addr  input  AW  read port B register select.
REQ-008 A  output  W  port A read data; drives ALU operand A.
REQ-009 B  output  W  port B read data; drives ALU operand B.
REQ-010 wr_en  input  1  write enable for the write port.
REQ-011 wr_addr  input  AW  write register select.
REQ-012 wr_data  input  W  write data; normally ALU_o.
REQ-013 flag_we  input  1  flag register capture enable.
REQ-014 zero_in  input  1  ALU zero result to capture.
REQ-015 cout_in  input  1  ALU carry-out to capture.
REQ-016 zero_f  output  1  registered zero flag.
REQ-017 carry_f  output  1  registered carry flag.

Function
REQ-018 Storage SHALL be NREG registers of W bits; R0 SHALL always read 0 and SHALL never be written.
REQ-019 On a rising clk edge with wr_en=1 and wr_addr!=0, register[wr_addr] SHALL take wr_data; with wr_en=0 or wr_addr=0, no register SHALL change.
REQ-020 A and B SHALL be combinational reads of register[ra_addr] and register[rb_addr], zero latency from address change.
REQ-021 ra_addr=rb_addr SHALL return identical data on A and B.
REQ-022 On a rising edge with flag_we=1, zero_f SHALL take zero_in and carry_f SHALL take cout_in in the same edge; with flag_we=0 both SHALL hold.
REQ-023 Register writes and flag captures SHALL be independent; both SHALL occur when wr_en and flag_we are high in the same cycle.
REQ-024 Read-during-write to the same nonzero address: the behaviour SHALL be as set by REQ-030/REQ-031.
REQ-025 Address values are always in range for NREG a power of two; NREG SHALL be a power of two, minimum 2.

Reset
REQ-026 rst_n=0 SHALL immediately, without a clock edge, clear all registers, zero_f and carry_f to 0.
REQ-027 During reset, A=0, B=0, zero_f=0 and carry_f=0 for any address input; wr_en and flag_we SHALL be ignored.
REQ-028 A reset asserted mid-operation SHALL discard any write in the same cycle; the first write SHALL take effect on the first rising edge after rst_n returns to 1.

Configuration
REQ-029 The macro RF_BYPASS_EN SHALL control write-to-read forwarding.
REQ-030 With RF_BYPASS_EN defined: when wr_en=1, wr_addr!=0 and wr_addr equals ra_addr (or rb_addr), A (or B) SHALL show wr_data combinationally in that same cycle.
REQ-031 With RF_BYPASS_EN undefined: A and B SHALL show the pre-edge stored value in the write cycle and the new value only after the rising edge.
REQ-032 Writes to R0 SHALL never be forwarded in either configuration.

Verification
REQ-033 Reset: rst_n=0, any addresses -> A=0, B=0, zero_f=0, carry_f=0; after release, reading R1..R7 returns 0.
REQ-034 Write/read: write 0xA5 to R3, then 0x3C to R5; set ra=3, rb=5 -> A=0xA5, B=0x3C; feed both to the ALU with ALU_ctrl=2, write ALU_o to R6 -> R6=0xE1.
REQ-035 R0 protection: wr_en=1, wr_addr=0, wr_data=0xFF -> ra=0 reads 0x00; no other register changes.
REQ-036 Flags: zero_in=1, cout_in=1, flag_we=1 for one edge -> zero_f=1, carry_f=1; next cycle flag_we=0 with inputs 0 -> flags hold 1.
REQ-037 Bypass: R2=0x10; cycle with wr_en=1, wr_addr=2, wr_data=0x77, ra=2 -> A=0x77 before the edge with RF_BYPASS_EN, A=0x10 before and 0x77 after without.
REQ-038 Async reset mid-write: rst_n low between edges while wr_en=1 to R4 with 0x55 -> R4=0 after release; flags=0.
